ir_field_extender: RTL and testbench

- Parametrised, pipelined immediate/offset extractor for the SLC-3 datapath.
- Replaces the fixed-width SEXT5/6/9/11 combinational extenders with one block. A runtime mode selects the IR field and whether it is sign- or zero-extended, with an optional left-shift-by-1.
- Output is registered through LATENCY stages with a valid/ready handshake. It feeds the ADDR2/SR2 muxes and can be stalled by the consumer.

---
 rtl/ext_pkg.sv | 21 ++
 rtl/ext_stage.sv | 45 ++++
 rtl/ir_field_extender.sv | 100 ++++++++++
 tb/tb_ir_field_extender.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// rtl/ext_pkg.sv - mode encoding and field widths for the IR immediate/offset extender
package ext_pkg;

  typedef enum logic [2:0] {
    EXT_SEXT5  = 3'b000,
    EXT_SEXT6  = 3'b001,
    EXT_SEXT9  = 3'b010,
    EXT_SEXT11 = 3'b011,
    EXT_ZEXT8  = 3'b100,
    EXT_ZERO   = 3'b101,
    EXT_RSV6   = 3'b110,
    EXT_RSV7   = 3'b111
  } ext_mode_t;

  localparam int unsigned SEXT5_W  = 5;
  localparam int unsigned SEXT6_W  = 6;
  localparam int unsigned SEXT9_W  = 9;
  localparam int unsigned SEXT11_W = 11;
  localparam int unsigned ZEXT8_W  = 8;

endpackage

// File: rtl/ext_stage.sv
// rtl/ext_stage.sv - one valid/ready register slice carrying an {ext, mode_err} word
module ext_stage #(
  parameter int unsigned W = 17
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // An empty slot, or one draining this cycle, can take the next word.
  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/ir_field_extender.sv
// rtl/ir_field_extender.sv - runtime-selected IR field sign/zero extender with optional shift and LATENCY-deep skid-free pipeline
module ir_field_extender
  import ext_pkg::*;
#(
  parameter int unsigned IN_W    = 16,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned LATENCY = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  ir,
  input  logic [2:0]       mode,
  input  logic             lshf1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] ext,
  output logic             mode_err
);

  localparam int unsigned DW = OUT_W + 1;

  if (IN_W < 11) begin : g_bad_in_w
    $error("ir_field_extender: IN_W must be >= 11");
  end
  if (OUT_W < 12) begin : g_bad_out_w
    $error("ir_field_extender: OUT_W must be >= 12");
  end
  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("ir_field_extender: LATENCY must be in 1..4");
  end

  ext_mode_t        mode_e;
  logic [OUT_W-1:0] ext_raw;
  logic [OUT_W-1:0] ext_shf;
  logic             err_raw;
  logic             unused_ir;

  assign mode_e    = ext_mode_t'(mode);
  assign unused_ir = ^{1'b0, ir};

  always_comb begin
    ext_raw = '0;
    err_raw = 1'b0;
    case (mode_e)
      EXT_SEXT5:  ext_raw = {{(OUT_W-SEXT5_W){ir[SEXT5_W-1]}},   ir[SEXT5_W-1:0]};
      EXT_SEXT6:  ext_raw = {{(OUT_W-SEXT6_W){ir[SEXT6_W-1]}},   ir[SEXT6_W-1:0]};
      EXT_SEXT9:  ext_raw = {{(OUT_W-SEXT9_W){ir[SEXT9_W-1]}},   ir[SEXT9_W-1:0]};
      EXT_SEXT11: ext_raw = {{(OUT_W-SEXT11_W){ir[SEXT11_W-1]}}, ir[SEXT11_W-1:0]};
      EXT_ZEXT8:  ext_raw = {{(OUT_W-ZEXT8_W){1'b0}},            ir[ZEXT8_W-1:0]};
      EXT_ZERO:   ext_raw = '0;
      default:    err_raw = 1'b1;
    endcase
  end

  // Shifting a zero value is harmless, so ZERO/reserved need no special case.
  assign ext_shf = lshf1 ? {ext_raw[OUT_W-2:0], 1'b0} : ext_raw;

  logic [LATENCY:0]   vld;
  logic [LATENCY-1:0] down_rdy;
  logic [LATENCY-1:0] stage_rdy;
  logic [DW-1:0]      data [LATENCY+1];
  logic               unused_rdy;
  logic               acc;

  assign vld[0]  = in_valid;
  assign data[0] = {ext_shf, err_raw};

  // Downstream readiness is rebuilt from the valid bits so the ready chain
  // never loops back through a single vector.
  always_comb begin
    acc = out_ready;
    down_rdy = '0;
    for (int k = LATENCY - 1; k >= 0; k--) begin
      down_rdy[k] = acc;
      acc = acc || !vld[k+1];
    end
  end

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    ext_stage #(.W(DW)) u_stage (
      .Clk       (Clk),
      .Reset     (Reset),
      .in_valid  (vld[k]),
      .in_ready  (stage_rdy[k]),
      .in_data   (data[k]),
      .out_valid (vld[k+1]),
      .out_ready (down_rdy[k]),
      .out_data  (data[k+1])
    );
  end

  assign unused_rdy = ^stage_rdy;
  assign in_ready   = stage_rdy[0];
  assign out_valid  = vld[LATENCY];
  assign ext        = data[LATENCY][DW-1:1];
  assign mode_err   = data[LATENCY][0];

endmodule

// File: tb/tb_ir_field_extender.sv
// tb/tb_ir_field_extender.sv - directed and soak checks of ir_field_extender at three parameter points
module tb_ir_field_extender;

  logic Clk, Reset;

  logic        a_in_valid, a_in_ready, a_lshf1, a_out_valid, a_out_ready, a_mode_err;
  logic [15:0] a_ir, a_ext;
  logic [2:0]  a_mode;

  logic        b_in_valid, b_in_ready, b_lshf1, b_out_valid, b_out_ready, b_mode_err;
  logic [15:0] b_ir, b_ext;
  logic [2:0]  b_mode;

  logic        c_in_valid, c_in_ready, c_lshf1, c_out_valid, c_out_ready, c_mode_err;
  logic [15:0] c_ir;
  logic [31:0] c_ext;
  logic [2:0]  c_mode;

  int checks = 0;
  int errors = 0;

  logic [32:0] q[$];
  logic        prev_stall;
  logic [32:0] prev_word;
  logic        ghost;

  ir_field_extender #(.IN_W(16), .OUT_W(16), .LATENCY(2)) dut_a (
    .Clk(Clk), .Reset(Reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .ir(a_ir), .mode(a_mode), .lshf1(a_lshf1), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .ext(a_ext), .mode_err(a_mode_err));

  ir_field_extender #(.IN_W(16), .OUT_W(16), .LATENCY(3)) dut_b (
    .Clk(Clk), .Reset(Reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .ir(b_ir), .mode(b_mode), .lshf1(b_lshf1), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .ext(b_ext), .mode_err(b_mode_err));

  ir_field_extender #(.IN_W(16), .OUT_W(32), .LATENCY(4)) dut_c (
    .Clk(Clk), .Reset(Reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .ir(c_ir), .mode(c_mode), .lshf1(c_lshf1), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .ext(c_ext), .mode_err(c_mode_err));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [32:0] model(input logic [15:0] irv, input logic [2:0] m, input logic s);
    logic [31:0] v;
    int          w;
    bit          sgn;
    v = 32'h0; w = 0; sgn = 1'b0;
    case (m)
      3'd0: begin w = 5;  sgn = 1'b1; end
      3'd1: begin w = 6;  sgn = 1'b1; end
      3'd2: begin w = 9;  sgn = 1'b1; end
      3'd3: begin w = 11; sgn = 1'b1; end
      3'd4: begin w = 8;  sgn = 1'b0; end
      default: w = 0;
    endcase
    if (w > 0) begin
      v = {16'h0, irv} & ((32'h1 << w) - 32'h1);
      if (sgn && irv[w-1]) v = v | ~((32'h1 << w) - 32'h1);
      if (s) v = v << 1;
    end
    return {(m >= 3'd6), v};
  endfunction

  task automatic single_a(input logic [15:0] irv, input logic [2:0] m, input logic s,
                          input logic [15:0] exp_ext, input logic exp_err, input string tag);
    a_ir = irv; a_mode = m; a_lshf1 = s; a_in_valid = 1'b1; a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick();
    chk({tag, "_vld"}, a_out_valid, 1'b1);
    chk(tag, a_ext, exp_ext);
    chk({tag, "_err"}, a_mode_err, exp_err);
    tick();
  endtask

  task automatic sample_c();
    if (prev_stall) begin
      chk("soak_hold_vld", c_out_valid, 1'b1);
      chk("soak_hold", {c_mode_err, c_ext}, prev_word);
    end
    if (c_out_valid && c_out_ready) begin
      if (q.size() == 0) chk("soak_spurious", 1'b1, 1'b0);
      else chk("soak_word", {c_mode_err, c_ext}, q.pop_front());
    end
    if (c_in_valid && c_in_ready) q.push_back(model(c_ir, c_mode, c_lshf1));
    prev_stall = c_out_valid && !c_out_ready;
    prev_word  = {c_mode_err, c_ext};
  endtask

  initial begin
    Reset = 1'b1;
    a_in_valid = 0; a_ir = 0; a_mode = 0; a_lshf1 = 0; a_out_ready = 0;
    b_in_valid = 0; b_ir = 0; b_mode = 0; b_lshf1 = 0; b_out_ready = 0;
    c_in_valid = 0; c_ir = 0; c_mode = 0; c_lshf1 = 0; c_out_ready = 0;
    prev_stall = 1'b0; prev_word = '0; ghost = 1'b0;
    tick();
    tick();
    chk("rst_a_vld", a_out_valid, 1'b0);
    chk("rst_a_ext", a_ext, 16'h0);
    chk("rst_a_err", a_mode_err, 1'b0);
    chk("rst_a_rdy", a_in_ready, 1'b1);
    chk("rst_b_vld", b_out_valid, 1'b0);
    chk("rst_c_vld", c_out_valid, 1'b0);
    chk("rst_c_ext", c_ext, 32'h0);
    Reset = 1'b0;

    single_a(16'h001F, 3'b000, 1'b0, 16'hFFFF, 1'b0, "sext5_1f");
    single_a(16'h0530, 3'b000, 1'b0, 16'hFFF0, 1'b0, "sext5_530");
    single_a(16'h0530, 3'b001, 1'b0, 16'hFFF0, 1'b0, "sext6");
    single_a(16'h0530, 3'b010, 1'b0, 16'hFF30, 1'b0, "sext9");
    single_a(16'h0530, 3'b011, 1'b0, 16'hFD30, 1'b0, "sext11");
    single_a(16'h0530, 3'b100, 1'b0, 16'h0030, 1'b0, "zext8");
    single_a(16'h0530, 3'b101, 1'b0, 16'h0000, 1'b0, "zero");
    single_a(16'h0530, 3'b110, 1'b0, 16'h0000, 1'b1, "rsv6");
    single_a(16'h0530, 3'b111, 1'b1, 16'h0000, 1'b1, "rsv7_shift");
    single_a(16'h0400, 3'b011, 1'b1, 16'hF800, 1'b0, "sext11_shift");
    single_a(16'h0400, 3'b101, 1'b1, 16'h0000, 1'b0, "zero_shift");
    single_a(16'hFFEF, 3'b000, 1'b0, 16'h000F, 1'b0, "sext5_upper_ignored");
    single_a(16'h00FF, 3'b100, 1'b1, 16'h01FE, 1'b0, "zext8_shift");

    // backpressure on the three-stage instance
    b_out_ready = 1'b0; b_mode = 3'b100; b_lshf1 = 1'b0; b_in_valid = 1'b1;
    b_ir = 16'h0011; #1 chk("bp_rdy1", b_in_ready, 1'b1); tick();
    b_ir = 16'h0022; #1 chk("bp_rdy2", b_in_ready, 1'b1); tick();
    b_ir = 16'h0033; #1 chk("bp_rdy3", b_in_ready, 1'b1); tick();
    b_ir = 16'h0044; #1;
    chk("bp_full_rdy", b_in_ready, 1'b0);
    chk("bp_full_vld", b_out_valid, 1'b1);
    chk("bp_head", b_ext, 16'h0011);
    tick();
    chk("bp_hold", b_ext, 16'h0011);
    chk("bp_hold_rdy", b_in_ready, 1'b0);
    b_out_ready = 1'b1; #1;
    chk("bp_drain_accept", b_in_ready, 1'b1);
    tick();
    b_out_ready = 1'b0; b_ir = 16'h0055; #1;
    chk("bp_second", b_ext, 16'h0022);
    chk("bp_refull_rdy", b_in_ready, 1'b0);
    tick();
    chk("bp_second_hold", b_ext, 16'h0022);
    b_out_ready = 1'b1;
    tick();
    b_in_valid = 1'b0;
    chk("bp_third", b_ext, 16'h0033);
    tick();
    chk("bp_fourth", b_ext, 16'h0044);
    tick();
    chk("bp_fifth", b_ext, 16'h0055);
    chk("bp_fifth_vld", b_out_valid, 1'b1);
    tick();
    chk("bp_empty", b_out_valid, 1'b0);

    // reset with results in flight
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_ir = 16'h0066;
    tick();
    b_ir = 16'h0077;
    tick();
    b_in_valid = 1'b0; Reset = 1'b1;
    tick();
    chk("mrst_vld", b_out_valid, 1'b0);
    chk("mrst_ext", b_ext, 16'h0);
    chk("mrst_rdy", b_in_ready, 1'b1);
    Reset = 1'b0; b_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (b_out_valid) ghost = 1'b1;
    end
    chk("mrst_no_ghost", ghost, 1'b0);

    // 32-bit, four-stage latency
    c_out_ready = 1'b1; c_ir = 16'h0100; c_mode = 3'b010; c_lshf1 = 1'b0; c_in_valid = 1'b1;
    tick();
    c_in_valid = 1'b0;
    tick();
    tick();
    chk("c_lat_early", c_out_valid, 1'b0);
    tick();
    chk("c_lat_vld", c_out_valid, 1'b1);
    chk("c_sext9", c_ext, 32'hFFFFFF00);
    chk("c_sext9_err", c_mode_err, 1'b0);
    tick();
    chk("c_drained", c_out_valid, 1'b0);

    for (int i = 0; i < 400; i++) begin
      c_in_valid  = ($urandom_range(0, 3) != 0);
      c_out_ready = ($urandom_range(0, 2) != 0);
      c_ir        = 16'($urandom());
      c_mode      = 3'($urandom_range(0, 7));
      c_lshf1     = 1'($urandom_range(0, 1));
      #1;
      sample_c();
      tick();
    end
    c_in_valid = 1'b0; c_out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      sample_c();
      tick();
    end
    chk("soak_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
